// File: rtl/crc_calculator.sv
// Streaming Rocksoft-model CRC engine, one DATA_WIDTH word absorbed per clock.
// Define CRC_CALC_ZERO_FLAG_EN to add the crc_zero_o residue flag output.
module crc_calculator #(
    parameter int unsigned           CRC_SIZE   = 8,
    parameter logic [CRC_SIZE-1:0]   POLY       = 8'h1D,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [CRC_SIZE-1:0]   INIT       = 8'hFF,
    parameter bit                    REF_IN     = 1'b1,
    parameter bit                    REF_OUT    = 1'b1,
    parameter logic [CRC_SIZE-1:0]   XOR_OUT    = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_SIZE-1:0]   crc_o
`ifdef CRC_CALC_ZERO_FLAG_EN
    ,
    output logic                  crc_zero_o
`endif
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [CRC_SIZE-1:0] r_q;
    logic [CRC_SIZE-1:0] r_d;
    logic [CRC_SIZE-1:0] r_out;

    function automatic logic [7:0] byte_in(input logic [7:0] b);
        logic [7:0] o;
        for (int k = 0; k < 8; k++) begin
            o[k] = REF_IN ? b[7-k] : b[k];
        end
        return o;
    endfunction

    // Whole word unrolled: MSB byte first, each byte MSB bit first.
    function automatic logic [CRC_SIZE-1:0] crc_next(
        input logic [CRC_SIZE-1:0]   r,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [CRC_SIZE-1:0] c;
        logic [7:0]          b;
        logic                fb;
        c = r;
        for (int i = NBYTES - 1; i >= 0; i--) begin
            b = byte_in(d[i*8 +: 8]);
            for (int j = 7; j >= 0; j--) begin
                fb = c[CRC_SIZE-1] ^ b[j];
                c  = c << 1;
                if (fb) begin
                    c = c ^ POLY;
                end
            end
        end
        return c;
    endfunction

    always_comb begin
        r_d = r_q;
        if (soft_reset_i) begin
            r_d = INIT;
        end else if (valid_i) begin
            r_d = crc_next(r_q, data_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= INIT;
        end else begin
            r_q <= r_d;
        end
    end

    always_comb begin
        r_out = r_q;
        if (REF_OUT) begin
            for (int k = 0; k < int'(CRC_SIZE); k++) begin
                r_out[k] = r_q[CRC_SIZE-1-k];
            end
        end
    end

    assign crc_o = r_out ^ XOR_OUT;

`ifdef CRC_CALC_ZERO_FLAG_EN
    assign crc_zero_o = (crc_o == '0);
`endif

endmodule

// File: tb/tb_crc_calculator.sv
// Directed bench for crc_calculator (default parameters) with a reflected
// LSB-first reference model checked every cycle.
module tb_crc_calculator;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       soft_reset_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic [7:0] crc_o;
`ifdef CRC_CALC_ZERO_FLAG_EN
    logic       crc_zero_o;
`endif

    int  n_vec = 0;
    int  n_bad = 0;
    bit  armed = 1'b0;
    logic [7:0] crc_m = 8'hFF;

    crc_calculator dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .soft_reset_i (soft_reset_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .crc_o        (crc_o)
`ifdef CRC_CALC_ZERO_FLAG_EN
        ,
        .crc_zero_o   (crc_zero_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Reflected table-free form: crc = (crc >> 1) ^ 0xB8 on lsb.
    function automatic logic [7:0] model_byte(input logic [7:0] c,
                                              input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int k = 0; k < 8; k++) begin
            x = x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
        end
        return x;
    endfunction

    always @(posedge clk_i) begin
        if (rst_i || soft_reset_i) crc_m <= 8'hFF;
        else if (valid_i) crc_m <= model_byte(crc_m, data_i);
    end

    always @(negedge clk_i) begin
        if (armed) begin
            n_vec++;
            if (crc_o !== crc_m) begin
                n_bad++;
                $display("FAIL cycle_crc: got %02h expected %02h at %0t",
                         crc_o, crc_m, $time);
            end
`ifdef CRC_CALC_ZERO_FLAG_EN
            n_vec++;
            if (crc_zero_o !== (crc_m == 8'h00)) begin
                n_bad++;
                $display("FAIL cycle_zero: got %0b expected %0b at %0t",
                         crc_zero_o, (crc_m == 8'h00), $time);
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        valid_i = 1'b0;
        soft_reset_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        valid_i = 1'b1;
        data_i = b;
        step();
        valid_i = 1'b0;
        data_i = 8'h00;
    endtask

    task automatic send_q(input logic [7:0] q[$], input bit gap);
        foreach (q[i]) begin
            send(q[i]);
            if (gap) step();
        end
    endtask

    task automatic soft_restart(input bit with_valid, input logic [7:0] b);
        soft_reset_i = 1'b1;
        valid_i = with_valid;
        data_i = b;
        step();
        soft_reset_i = 1'b0;
        valid_i = 1'b0;
    endtask

    // Literal check in the cycle after the last valid byte; pins model too.
    task automatic check_lit(input string name, input logic [7:0] exp);
        @(negedge clk_i);
        n_vec++;
        if (crc_o !== exp) begin
            n_bad++;
            $display("FAIL %s: crc_o %02h expected %02h", name, crc_o, exp);
        end
        n_vec++;
        if (crc_m !== exp) begin
            n_bad++;
            $display("FAIL %s_model: model %02h expected %02h",
                     name, crc_m, exp);
        end
`ifdef CRC_CALC_ZERO_FLAG_EN
        n_vec++;
        if (crc_zero_o !== (exp == 8'h00)) begin
            n_bad++;
            $display("FAIL %s_zero: got %0b expected %0b",
                     name, crc_zero_o, (exp == 8'h00));
        end
`endif
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [7:0] q4[$];
        logic [7:0] s9[$];
        logic [7:0] r23[$];
        q4  = '{8'h12, 8'hAB, 8'h34, 8'hCD};
        s9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39};
        r23 = '{8'hA1, 8'h29, 8'hBB, 8'h29, 8'h30, 8'h00, 8'h02, 8'h13,
                8'h99, 8'hBF, 8'hF9, 8'h30, 8'hEE, 8'hBA, 8'h99, 8'h22,
                8'h20, 8'h19, 8'h82, 8'h37, 8'h49, 8'hCD, 8'hD1};

        #1;
        do_reset();
        armed = 1'b1;
        step();
        check_lit("idle_reset", 8'hFF);

        do_reset();
        send(8'hFF);
        send(8'hFF);
        check_lit("ff_ff", 8'h23);

        do_reset();
        send(8'hCD);
        check_lit("single_cd", 8'hF1);

        do_reset();
        send_q(q4, 1'b0);
        check_lit("four_bytes", 8'h6B);

        do_reset();
        send_q(q4, 1'b1);
        check_lit("four_gapped", 8'h6B);

        do_reset();
        send_q(s9, 1'b0);
        check_lit("check_str", 8'h97);

        do_reset();
        for (int i = 0; i < 4; i++) send(s9[i]);
        soft_restart(1'b0, 8'h00);
        check_lit("soft_idle", 8'hFF);
        send_q(s9, 1'b0);
        check_lit("soft_restart", 8'h97);

        do_reset();
        send(8'h5A);
        soft_restart(1'b1, 8'h77);
        check_lit("soft_drop", 8'hFF);
        send_q(s9, 1'b0);
        check_lit("soft_drop_msg", 8'h97);

        do_reset();
        send(8'hAA);
        send(8'h55);
        do_reset();
        send(8'hCD);
        check_lit("reset_midmsg", 8'hF1);

        do_reset();
        send_q(r23, 1'b0);
        check_lit("residue", 8'h00);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) send(8'($urandom));
            else step();
        end
        step();

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/crc_calculator.md
# crc_calculator

Parameterised, streaming CRC engine (Rocksoft model) for the link datapath. Absorbs one DATA_WIDTH-bit word per clock while valid_i is high and continuously presents the finalised CRC of every word accepted since the last reset or soft reset. Used both to generate frame CRCs (default CRC-8, poly 0x1D) and to check received frames by residue.

## Interface
- POLY, 8'h1D: generator polynomial, implicit top bit omitted, normal (non-reflected) form.
- CRC_SIZE, 8: CRC width in bits, 1..64.
- DATA_WIDTH, 8: input word width; positive multiple of 8.
- INIT, 8'hFF: CRC register value loaded on reset or soft reset (CRC_SIZE bits).
- REF_IN, 1: 1 = reflect bit order within each input byte.
- REF_OUT, 1: 1 = reflect the full CRC_SIZE register before output XOR.
- XOR_OUT, 8'h00: value XORed onto the output (CRC_SIZE bits).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- soft_reset_i  in  1  synchronous restart: reload INIT, begin a new message.
- valid_i  in  1  data_i holds a word to absorb this cycle.
- data_i  in  DATA_WIDTH  input word; most-significant byte is processed first.
- crc_o  out  CRC_SIZE  finalised CRC of all accepted words.

## Operation
- Internal CRC register `r`, CRC_SIZE bits, the only state.
- Per rising edge, in priority order:
  - rst_i = 1: r <= INIT.
  - soft_reset_i = 1: r <= INIT. A word presented with valid_i in the same cycle is discarded.
  - valid_i = 1: r <= next(r, data_i).
  - Otherwise: r holds.
- next(): process DATA_WIDTH/8 bytes, MSB byte first.
  - Each byte is bit-reversed first if REF_IN = 1.
  - Each byte's bits are fed MSB first into a normal-form shift register. Per bit: fb = r[CRC_SIZE-1] ^ bit; r = (r << 1) truncated to CRC_SIZE; if fb, r ^= POLY.
  - The whole word is unrolled into one combinational update with no multicycle path.
- crc_o = (REF_OUT ? reverse(r) : r) ^ XOR_OUT. This is combinational from r; no extra register.
- With the default parameters, bytes fed LSB-first in reflected form are equivalent: crc = (crc >> 1) ^ 0xB8 on lsb.
- Widths: all arithmetic is mod 2, truncated to CRC_SIZE. POLY, INIT and XOR_OUT are taken as their low CRC_SIZE bits.
- No backpressure: every valid_i cycle is accepted. An unlimited message length is supported.

## Timing
- Latency: a word sampled at edge N is reflected in crc_o immediately after edge N, with zero added cycles. Reading crc_o in the cycle after the last valid word gives the final CRC.
- Reset value: r = INIT. crc_o = finalised INIT, which is 0xFF for the defaults.
- After rst_i or soft_reset_i deasserts, the next valid word is absorbed at the following edge.
- Reset mid-message: the partial CRC is discarded with no residual effect.
- valid_i low between words (gaps) does not affect the result.
- crc_o is stable while valid_i is low.

## Configuration
- CRC_CALC_ZERO_FLAG_EN defined: adds output port crc_zero_o (in the port list after crc_o), 1 bit, combinational, equal to (crc_o == 0). It is used for receive-side residue checking: a message plus its appended CRC gives 0 with the default parameters.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use default parameters, apply rst_i for 2 cycles before each message, and check crc_o in the cycle after the last valid byte.
- Idle after reset, valid_i low -> crc_o = 0xFF.
- Bytes 0xFF, 0xFF -> crc_o = 0x23.
- Single byte 0xCD -> crc_o = 0xF1.
- Bytes 0x12, 0xAB, 0x34, 0xCD -> crc_o = 0x6B. Repeat with one idle (valid_i low) cycle between bytes -> still 0x6B.
- ASCII "123456789" (0x31..0x39) -> crc_o = 0x97. Assert soft_reset_i after the 4th byte, then send "123456789" -> 0x97. Assert soft_reset_i with valid_i high on a byte -> that byte is ignored.
- 23 bytes A1 29 BB 29 30 00 02 13 99 BF F9 30 EE BA 99 22 20 19 82 37 49 CD D1 -> crc_o = 0x00, and crc_zero_o = 1 when CRC_CALC_ZERO_FLAG_EN is defined.
